// File: rtl/serial_paralelo_sync_if.sv
// Receive-side bundle for the serial-to-parallel aligner: serial bit in, aligned
// parallel word plus qualifiers out.
interface serial_paralelo_sync_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             word_strobe;
  logic             active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  word_strobe,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output word_strobe,
    output active
  );

endinterface

// File: rtl/serial_paralelo_sync.sv
// Bit-rate serial-to-parallel receiver: hunts for the comma word, locks word
// alignment after SYNC_COUNT aligned commas, then emits data words with a valid flag.
module serial_paralelo_sync #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM        = 8'hBC,
  parameter logic [WIDTH-1:0] IDL        = 8'h7C,
  parameter int unsigned      SYNC_COUNT = 4
) (
  input logic                   clk_32f,
  input logic                   reset_L,
  serial_paralelo_sync_if.slave bus
);

  localparam int unsigned BitW = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(SYNC_COUNT + 1);

  typedef enum logic [1:0] {StHunt, StAlign, StActive} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] data_q, data_d;
  logic [BitW-1:0]  bitcnt_q, bitcnt_d;
  logic [CntW-1:0]  comcnt_q, comcnt_d, comcnt_inc;
  logic             valid_q, valid_d;
  logic             strobe_q, strobe_d;
  logic             boundary;

  // Word under test includes the bit being sampled on this edge.
  assign cand       = {sr_q[WIDTH-2:0], bus.data_in};
  assign boundary   = (bitcnt_q == BitW'(WIDTH - 1));
  assign comcnt_inc = comcnt_q + CntW'(1);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = boundary ? '0 : bitcnt_q + BitW'(1);
    comcnt_d = comcnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;

    unique case (state_q)
      StHunt: begin
        // A match here defines the boundary; the next bit is bit 0 of a word.
        bitcnt_d = '0;
        if (cand == COM) begin
          comcnt_d = CntW'(1);
          state_d  = (SYNC_COUNT == 1) ? StActive : StAlign;
        end
      end
      StAlign: begin
        if (boundary) begin
          if (cand == COM) begin
            comcnt_d = comcnt_inc;
            if (comcnt_inc == CntW'(SYNC_COUNT)) state_d = StActive;
          end else begin
            comcnt_d = '0;
            state_d  = StHunt;
          end
        end
      end
      StActive: begin
        if (boundary) begin
          strobe_d = 1'b1;
          if (cand == COM || cand == IDL) begin
            valid_d = 1'b0;
          end else begin
            data_d  = cand;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= StHunt;
      sr_q     <= '0;
      bitcnt_q <= '0;
      comcnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= cand;
      bitcnt_q <= bitcnt_d;
      comcnt_q <= comcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.word_strobe = strobe_q;
  assign bus.active      = (state_q == StActive);

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Directed bench for serial_paralelo_sync: lock sequence, data/comma/idle
// classification table, failed alignment, and asynchronous reset while locked.
module tb_serial_paralelo_sync;

  logic clk_32f = 1'b0;
  logic reset_L;

  serial_paralelo_sync_if #(.WIDTH(8)) bus ();

  serial_paralelo_sync #(
    .WIDTH     (8),
    .COM       (8'hBC),
    .IDL       (8'h7C),
    .SYNC_COUNT(4)
  ) dut (
    .clk_32f(clk_32f),
    .reset_L(reset_L),
    .bus    (bus)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] word;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one bit, let the next rising edge sample it, then settle.
  task automatic send_bit(input logic b);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Send a word MSB first, counting edges with active high and valid high.
  task automatic send_word(input logic [7:0] w, output int act_hi, output int val_hi);
    act_hi = 0;
    val_hi = 0;
    for (int b = 7; b >= 0; b--) begin
      send_bit(w[b]);
      if (bus.active === 1'b1) act_hi++;
      if (bus.valid_out === 1'b1) val_hi++;
    end
  endtask

  // Send four commas bit by bit; active must rise exactly on the 32nd edge.
  task automatic lock_sequence(input string tag);
    logic [7:0] com;
    int         val_hi;
    com    = 8'hBC;
    val_hi = 0;
    for (int k = 1; k <= 32; k++) begin
      send_bit(com[7 - ((k - 1) % 8)]);
      if (bus.valid_out === 1'b1) val_hi++;
      if (k == 31) check({tag, "_active_before_lock"}, 32'(bus.active), 32'd0);
      if (k == 32) begin
        check({tag, "_active_at_lock"}, 32'(bus.active), 32'd1);
        check({tag, "_no_strobe_on_lock"}, 32'(bus.word_strobe), 32'd0);
      end
    end
    check({tag, "_valid_low_during_lock"}, 32'(val_hi), 32'd0);
  endtask

  vec_t       vecs[7];
  logic       prev_valid;
  logic [7:0] prev_data;
  logic [7:0] w;
  int         cnt_a, cnt_b, cnt_c, cnt_d, act_hi, val_hi, mid_strobe, hold_bad;

  initial begin
    vecs[0] = '{word: 8'h5A, exp_valid: 1'b1, exp_data: 8'h5A};
    vecs[1] = '{word: 8'hC3, exp_valid: 1'b1, exp_data: 8'hC3};
    vecs[2] = '{word: 8'hBC, exp_valid: 1'b0, exp_data: 8'hC3};
    vecs[3] = '{word: 8'h7C, exp_valid: 1'b0, exp_data: 8'hC3};
    vecs[4] = '{word: 8'h00, exp_valid: 1'b1, exp_data: 8'h00};
    vecs[5] = '{word: 8'h7C, exp_valid: 1'b0, exp_data: 8'h00};
    vecs[6] = '{word: 8'hFF, exp_valid: 1'b1, exp_data: 8'hFF};

    // Reset held with random serial input.
    reset_L     = 1'b0;
    bus.data_in = 1'b0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    for (int i = 0; i < 10; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      if (bus.active !== 1'b0) cnt_a++;
      if (bus.valid_out !== 1'b0) cnt_b++;
      if (bus.data_out !== 8'h00) cnt_c++;
      if (bus.word_strobe !== 1'b0) cnt_d++;
    end
    check("rst_active", 32'(cnt_a), 32'd0);
    check("rst_valid", 32'(cnt_b), 32'd0);
    check("rst_data", 32'(cnt_c), 32'd0);
    check("rst_strobe", 32'(cnt_d), 32'd0);

    // Release between edges, junk bits, then lock.
    reset_L = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("junk_active", 32'(bus.active), 32'd0);
    lock_sequence("lock1");

    // Classification table while locked.
    prev_valid = 1'b0;
    prev_data  = 8'h00;
    mid_strobe = 0;
    hold_bad   = 0;
    foreach (vecs[i]) begin
      w = vecs[i].word;
      for (int b = 7; b >= 0; b--) begin
        send_bit(w[b]);
        if (b != 0) begin
          if (bus.word_strobe !== 1'b0) mid_strobe++;
          if (bus.valid_out !== prev_valid || bus.data_out !== prev_data) hold_bad++;
        end
      end
      check($sformatf("vec%0d_strobe", i), 32'(bus.word_strobe), 32'd1);
      check($sformatf("vec%0d_valid", i), 32'(bus.valid_out), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_active", i), 32'(bus.active), 32'd1);
      prev_valid = vecs[i].exp_valid;
      prev_data  = vecs[i].exp_data;
    end
    check("tbl_no_mid_strobe", 32'(mid_strobe), 32'd0);
    check("tbl_outputs_hold", 32'(hold_bad), 32'd0);

    // Asynchronous reset three bits into a data word.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("pre_rst_data", 32'(bus.data_out), 32'hFF);
    reset_L = 1'b0;
    #1;
    check("async_rst_active", 32'(bus.active), 32'd0);
    check("async_rst_valid", 32'(bus.valid_out), 32'd0);
    check("async_rst_data", 32'(bus.data_out), 32'd0);
    check("async_rst_strobe", 32'(bus.word_strobe), 32'd0);
    @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int r = 0; r < 2; r++) begin
      send_word(8'h5A, act_hi, val_hi); cnt_a += act_hi; cnt_b += val_hi;
      send_word(8'hC3, act_hi, val_hi); cnt_a += act_hi; cnt_b += val_hi;
      send_word(8'h11, act_hi, val_hi); cnt_a += act_hi; cnt_b += val_hi;
      send_word(8'h22, act_hi, val_hi); cnt_a += act_hi; cnt_b += val_hi;
    end
    check("nocom_active", 32'(cnt_a), 32'd0);
    check("nocom_valid", 32'(cnt_b), 32'd0);

    // Broken comma run falls back to hunting, then a fresh run locks.
    reset_L = 1'b0;
    @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
    cnt_a = 0;
    send_word(8'hBC, act_hi, val_hi); cnt_a += act_hi;
    send_word(8'hBC, act_hi, val_hi); cnt_a += act_hi;
    send_word(8'h11, act_hi, val_hi); cnt_a += act_hi;
    check("broken_run_active", 32'(cnt_a), 32'd0);
    lock_sequence("lock2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_paralelo_sync.md
# serial_paralelo_sync

Parametrised serial-to-parallel receiver for the PHY receive path, clocked at the bit rate. It hunts for the COM comma word in a 1-bit serial stream and locks word alignment after `SYNC_COUNT` consecutive aligned COM words. Once locked it emits WIDTH-bit parallel words with a valid flag, treating COM and IDL words as non-data. It generalises the fixed 8-bit, fixed-alignment deserializer to any word width, any comma/idle code and any lock threshold.

## Interface
- `WIDTH`, 8, word width in bits (≥4)
- `COM`, 8'hBC, comma/sync word (must be non-zero)
- `IDL`, 8'h7C, idle word (must differ from COM)
- `SYNC_COUNT`, 4, consecutive aligned COM words required to lock (≥1)

- `clk_32f`  in  1  bit-rate clock, all logic on rising edge
- `reset_L`  in  1  reset, asynchronous, active-low
- `data_in`  in  1  serial data, MSB of each word first
- `data_out`  out  WIDTH  last received data word
- `valid_out`  out  1  high when the word at the last boundary was data
- `word_strobe`  out  1  one-cycle pulse at every word boundary while ACTIVE
- `active`  out  1  alignment locked

## Operation
- Shift register `sr` (WIDTH bits). Each edge: `sr <= {sr[WIDTH-2:0], data_in}`. The candidate word `cand = {sr[WIDTH-2:0], data_in}` is compared combinationally.
- Bit counter `bitcnt` (0..WIDTH-1) and COM counter `comcnt` (0..SYNC_COUNT).
- States:
  - HUNT: `cand` is checked every edge.
    - `cand==COM` with SYNC_COUNT==1 -> ACTIVE.
    - `cand==COM` otherwise -> ALIGN with `comcnt=1` and `bitcnt=0`.
    - The bit after the matching edge is bit 0 of the next word.
  - ALIGN: `bitcnt` increments each edge and wraps at WIDTH-1. At the word boundary (`bitcnt==WIDTH-1`):
    - `cand==COM`: `comcnt+1`. If `comcnt` reaches SYNC_COUNT -> ACTIVE.
    - Otherwise -> HUNT with `comcnt=0`. The failing word is not rescanned at other offsets; hunting resumes with the next bit.
  - ACTIVE: `bitcnt` keeps wrapping. At each boundary, `word_strobe=1` for that cycle.
    - `cand==COM` or `cand==IDL`: `valid_out<=0`, `data_out` holds.
    - Otherwise: `data_out<=cand`, `valid_out<=1`.
    - ACTIVE persists until reset; there is no loss-of-sync exit.
- In HUNT and ALIGN: `data_out=0`, `valid_out=0`, `word_strobe=0`.

## Timing
- Reset (asynchronous, `reset_L=0`): state=HUNT; `sr`, `bitcnt`, `comcnt`=0; `data_out=0`, `valid_out=0`, `word_strobe=0`, `active=0`. These values take effect immediately, without waiting for a clock edge.
- Reset released between edges: the first sampled bit is at the next rising edge.
- Outputs are registered. `data_out`, `valid_out` and `word_strobe` update on the same edge that samples the last (LSB) bit of the word.
  - `valid_out` and `data_out` hold for WIDTH cycles until the next boundary.
  - `word_strobe` is high for exactly 1 cycle every WIDTH cycles.
- `active` rises on the edge that samples the last bit of the SYNC_COUNT-th COM. The first data word boundary is WIDTH edges later.
- Lock latency from the first bit of the first COM = SYNC_COUNT·WIDTH edges, with the last bit sampled on edge SYNC_COUNT·WIDTH.
- A boundary COM on the locking edge does not produce a strobe; strobes start at the next boundary.
- Reset asserted mid-word in ACTIVE: all outputs drop at once. Relock requires SYNC_COUNT fresh COMs.

## Test plan
1. Reset held 10 cycles with random `data_in` -> `active=0`, `valid_out=0`, `data_out=0`, no `word_strobe`.
2. Three junk bits `101`, then BC,BC,BC,BC -> `active` rises on the edge sampling the 32nd bit after the first BC bit. `valid_out` stays 0 throughout.
3. After lock, send 0x5A then 0xC3 -> `word_strobe` every 8 cycles, `data_out=0x5A` with `valid_out=1`, then `data_out=0xC3` with `valid_out=1`.
4. In ACTIVE, send BC then 7C -> two strobes with `valid_out=0`, `data_out` holds 0xC3, `active` stays 1.
5. From reset, send BC,BC,0x11 -> return to HUNT, `active` never rises. A following BC×4 -> `active=1`.
6. Assert `reset_L=0` at bit 3 of a data word in ACTIVE -> outputs 0 before the next edge. After release, data without COMs -> `active` stays 0.
